fp_mod_addsub_pipe: RTL
=======================

Name: fp_mod_addsub_pipe

Overview:
- Pipelined modular adder/subtractor over Fp.
- Acts as the responder on the FE_TYPE add or subtract AXI-stream interface that Fp/Fp2 point-arithmetic blocks drive through resource_share.
- Accepts packed operand pairs and returns (a+b) mod P or (a-b) mod P. Full backpressure; ctl/mod/sop/eop/err pass through untouched, so arbiter tags survive the round trip.
- One instance per operation: SUB selects adder or subtractor.

Parameters:
- BITS, 381: operand/result width in bits.
- P, BLS12-381 base prime from shared package: modulus; must satisfy P < 2^BITS.
- SUB, 0: 0 computes a+b mod P; 1 computes a-b mod P.
- CTL_BITS, 16: width of ctl sideband, passed through verbatim.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (i_clk, i_rst).
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_axi  if_axi_stream.sink  DAT=2*BITS, CTL=CTL_BITS  request: dat[0 +: BITS]=a, dat[BITS +: BITS]=b; val/rdy/sop/eop/err/mod/ctl.
- o_axi  if_axi_stream.source  DAT=BITS, CTL=CTL_BITS  result: dat=result; val/rdy/sop/eop/err/mod/ctl.

Behaviour:
- Reset: o_axi.val=0; o_axi.dat/ctl/mod/sop/eop/err=0; all stage valid bits=0. Any in-flight operations are discarded with no output.
- Pipeline enable: en = ~o_axi.val || o_axi.rdy. i_axi.rdy = en (combinational). A transfer occurs when i_axi.val && i_axi.rdy.
- Stage 1 (captures request):
  - SUB=0: s1 = a + b, BITS+1 wide.
  - SUB=1: s1 = a - b, BITS+1 wide; MSB is the borrow.
  - Register sideband alongside.
- Stage 2: compute the correction candidate.
  - SUB=0: c = s1 - P, BITS+2 wide signed; keep s1.
  - SUB=1: c = s1[BITS-1:0] + P; keep s1 and the borrow.
- Stage 3 (select, registers into o_axi):
  - SUB=0: result = c negative ? s1[BITS-1:0] : c[BITS-1:0].
  - SUB=1: result = borrow ? c[BITS-1:0] : s1[BITS-1:0].
- Latency: exactly 3 cycles from the accepting edge to o_axi.val=1 when unstalled. Throughput 1/cycle.
- Stall: when en=0, every stage holds and no request is accepted. No data is lost or duplicated. Bubbles are not collapsed.
- Ordering: strictly in-order; each output carries the sideband of its own request.
- Operand contract: a, b < P. The result is then always < P. Out-of-range input yields an unspecified value unless the optional feature is enabled.
- Boundaries:
  - a+b = P gives 0.
  - a = b under SUB gives 0.
  - 0 - (P-1) gives 1.
  - (P-1) + (P-1) gives P-2.
- Simultaneous output accept and new input in the same cycle is legal: the pipeline advances and both transfers complete.
- o_axi.val is held until o_axi.rdy; dat is stable while val && ~rdy.

Optional Feature:
- Macro: FP_MOD_ADDSUB_RANGE_CHK_EN.
- Defined:
  - Stage 1 also flags (a >= P) || (b >= P).
  - That flag is ORed into the err sideband, which arrives on o_axi.err with that result.
  - Result value is still computed but undefined.
- Undefined: err is passed through unmodified and no comparators are built. Latency is identical in both builds.

Decomposition:
- Shared package (existing curve package): FE_TYPE typedef (logic [BITS-1:0]) and the modulus constant P. Stage-1 operand offsets are derived from $bits(FE_TYPE), not redeclared.
- Single module. No sub-module is natural; the three stages share one enable and one sideband bundle, so splitting them would only duplicate ports.

Test Plan:
- Use a bench override BITS=8, P=251, CTL_BITS=16.
- Add basics (SUB=0): a=250,b=3 gives 2; a=100,b=151 gives 0; a=250,b=250 gives 249; a=7,b=9 gives 16. Each appears exactly 3 cycles after acceptance.
- Sub basics (SUB=1): a=3,b=5 gives 249; a=0,b=250 gives 1; a=200,b=200 gives 0; a=9,b=7 gives 2.
- Backpressure: stream 20 back-to-back requests with ctl = index while o_axi.rdy toggles with a random 50% pattern. Outputs must match a reference model in order, with ctl 0..19, no drops or duplicates, and dat stable during stall.
- Sideband: send err=1, mod=0x55, sop=1, eop=0, ctl=0xBEEF. The output carries identical values alongside the correct result.
- Reset mid-operation: accept 3 requests, then assert i_rst for 1 cycle with o_axi.rdy=1. No o_axi.val appears for the flushed requests, and the next request completes with 3-cycle latency.
- Range check (build with FP_MOD_ADDSUB_RANGE_CHK_EN): a=251,b=0 gives o_axi.err=1; a=250,b=0 gives err=0. Without the macro, err stays 0 for both.

Source files
------------

// File: rtl/fp_mod_addsub_pipe_pkg.sv
// Shared curve package: field-element type, BLS12-381 base prime, sideband bundle.
package fp_mod_addsub_pipe_pkg;

  localparam int unsigned FE_BITS  = 381;
  localparam int unsigned MOD_BITS = 8;

  typedef logic [FE_BITS-1:0] FE_TYPE;

  // BLS12-381 base field modulus
  localparam FE_TYPE P_BLS12_381 =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  // Per-beat flags that ride alongside the data untouched (err may gain a range flag)
  typedef struct packed {
    logic [MOD_BITS-1:0] mod;
    logic                sop;
    logic                eop;
    logic                err;
  } sb_t;

endpackage

// File: rtl/fp_mod_addsub_pipe_if.sv
// AXI-stream style bus with val/rdy handshake and sop/eop/err/mod/ctl sideband.
interface fp_mod_addsub_pipe_if
  import fp_mod_addsub_pipe_pkg::*;
#(
  parameter int unsigned DAT_BITS = 2 * FE_BITS,
  parameter int unsigned CTL_BITS = 16,
  parameter int unsigned MOD_W    = MOD_BITS
) ();

  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_W-1:0]    mod;
  logic                sop;
  logic                eop;
  logic                err;

  modport source (output val, dat, ctl, mod, sop, eop, err, input rdy);
  modport sink   (input val, dat, ctl, mod, sop, eop, err, output rdy);
  modport master (output val, dat, ctl, mod, sop, eop, err, input rdy);
  modport slave  (input val, dat, ctl, mod, sop, eop, err, output rdy);

endinterface

// File: rtl/fp_mod_addsub_pipe.sv
// Pipelined modular adder/subtractor over Fp: (a+b) mod P when SUB=0, (a-b) mod P when SUB=1.
// Request capture, raw sum/difference, correction candidate, select into o_axi.
// o_axi.val rises on the third edge after the accepting edge; one shared stall enable.
// Build option FP_MOD_ADDSUB_RANGE_CHK_EN: flag a >= P or b >= P onto err.
module fp_mod_addsub_pipe
  import fp_mod_addsub_pipe_pkg::*;
#(
  parameter int unsigned     BITS     = $bits(FE_TYPE),
  parameter logic [BITS-1:0] P        = BITS'(P_BLS12_381),
  parameter bit              SUB      = 1'b0,
  parameter int unsigned     CTL_BITS = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fp_mod_addsub_pipe_if.sink   i_axi,
  fp_mod_addsub_pipe_if.source o_axi
);

  typedef logic [BITS-1:0] fe_t;

  localparam int unsigned W1    = BITS + 1;
  localparam int unsigned W2    = BITS + 2;
  localparam int unsigned B_LSB = $bits(fe_t);

  logic en;

  // Capture stage
  logic                r0_v;
  fe_t                 r0_a;
  fe_t                 r0_b;
  sb_t                 r0_sb;
  logic [CTL_BITS-1:0] r0_ctl;

  // Sum/difference stage
  logic                r1_v;
  logic [W1-1:0]       r1_s;
  sb_t                 r1_sb;
  logic [CTL_BITS-1:0] r1_ctl;

  // Correction-candidate stage
  logic                r2_v;
  logic [W1-1:0]       r2_s;
  logic [W2-1:0]       r2_c;
  sb_t                 r2_sb;
  logic [CTL_BITS-1:0] r2_ctl;

  logic [W1-1:0] s1_c;
  logic          range_err_c;
  sb_t           sb1_c;
  logic [W2-1:0] c_c;
  logic          use_c_c;
  fe_t           result_c;
  logic          unused_bits_c;

  // Whole pipeline advances together whenever the output slot can move
  assign en        = ~o_axi.val | o_axi.rdy;
  assign i_axi.rdy = en;

  // Capture the accepted operand pair and its sideband
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r0_v   <= 1'b0;
      r0_a   <= '0;
      r0_b   <= '0;
      r0_sb  <= '0;
      r0_ctl <= '0;
    end else if (en) begin
      r0_v   <= i_axi.val;
      r0_a   <= i_axi.dat[0 +: BITS];
      r0_b   <= i_axi.dat[B_LSB +: BITS];
      r0_sb  <= '{mod: i_axi.mod, sop: i_axi.sop, eop: i_axi.eop, err: i_axi.err};
      r0_ctl <= i_axi.ctl;
    end
  end

  // Raw sum, or difference whose MSB is the borrow
  always_comb begin
    s1_c = '0;
    if (SUB) s1_c = {1'b0, r0_a} - {1'b0, r0_b};
    else     s1_c = {1'b0, r0_a} + {1'b0, r0_b};
  end

`ifdef FP_MOD_ADDSUB_RANGE_CHK_EN
  // Operand contract violation, reported on err with this beat's result
  assign range_err_c = (r0_a >= P) || (r0_b >= P);
`else
  assign range_err_c = 1'b0;
`endif

  // Fold the optional range flag into the travelling err bit
  always_comb begin
    sb1_c     = r0_sb;
    sb1_c.err = r0_sb.err | range_err_c;
  end

  // Register the raw sum/difference
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_v   <= 1'b0;
      r1_s   <= '0;
      r1_sb  <= '0;
      r1_ctl <= '0;
    end else if (en) begin
      r1_v   <= r0_v;
      r1_s   <= s1_c;
      r1_sb  <= sb1_c;
      r1_ctl <= r0_ctl;
    end
  end

  // Correction candidate: s1 - P for add (sign says keep s1), s1 + P for sub
  always_comb begin
    c_c = '0;
    if (SUB) c_c = W2'(r1_s[BITS-1:0]) + W2'(P);
    else     c_c = W2'(r1_s) - W2'(P);
  end

  // Register the candidate beside the raw value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r2_v   <= 1'b0;
      r2_s   <= '0;
      r2_c   <= '0;
      r2_sb  <= '0;
      r2_ctl <= '0;
    end else if (en) begin
      r2_v   <= r1_v;
      r2_s   <= r1_s;
      r2_c   <= c_c;
      r2_sb  <= r1_sb;
      r2_ctl <= r1_ctl;
    end
  end

  // Pick the reduced value: borrow for sub, non-negative candidate for add
  always_comb begin
    use_c_c  = SUB ? r2_s[BITS] : ~r2_c[W2-1];
    result_c = use_c_c ? r2_c[BITS-1:0] : r2_s[BITS-1:0];
  end

  // Candidate bit BITS is never significant once operands are in range
  assign unused_bits_c = ^{r2_c[W2-1:BITS], r2_s[BITS]};

  // Output register; holds while the sink stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_axi.val <= 1'b0;
      o_axi.dat <= '0;
      o_axi.ctl <= '0;
      o_axi.mod <= '0;
      o_axi.sop <= 1'b0;
      o_axi.eop <= 1'b0;
      o_axi.err <= 1'b0;
    end else if (en) begin
      o_axi.val <= r2_v;
      o_axi.dat <= result_c;
      o_axi.ctl <= r2_ctl;
      o_axi.mod <= r2_sb.mod;
      o_axi.sop <= r2_sb.sop;
      o_axi.eop <= r2_sb.eop;
      o_axi.err <= r2_sb.err;
    end
  end

endmodule
